risc16_processor: RTL and testbench

- Single-cycle, 16-bit, 8-register RISC core with internal instruction and data memories.
- Retires one instruction per rising clock edge.
- Top-level unit of the CPU subsystem; the bench preloads the memories hierarchically and inspects registers and memory after the run.

---
 rtl/risc16_processor.sv | 140 ++++++++++++++
 tb/tb_risc16_processor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_processor.sv
// risc16_processor: single-cycle 16-bit, 8-register RISC core.
// Instruction and data memories are internal; dmem writes on the clock edge.
module risc16_processor #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];

  logic [15:0] pc_q, pc_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];
  logic        c_q, c_d;
  logic        z_q, z_d;

  logic [15:0] instr;
  logic [3:0]  op;
  logic [2:0]  ra, rb, rc;
  logic [1:0]  cz;
  logic [15:0] va, vb;
  logic [15:0] imm6, imm9;
  logic [15:0] pc_inc;
  logic [7:0]  ea;
  logic [15:0] ld;
  logic [16:0] sum, adi;
  logic [15:0] nd;
  logic        cond_ok;
  logic        dmem_we;

  assign instr = imem[pc_q[7:0]];
  assign op    = instr[15:12];
  assign ra    = instr[11:9];
  assign rb    = instr[8:6];
  assign rc    = instr[5:3];
  assign cz    = instr[1:0];
  assign va    = rf_q[ra];
  assign vb    = rf_q[rb];
  assign imm6  = {{10{instr[5]}}, instr[5:0]};
  assign imm9  = {{7{instr[8]}}, instr[8:0]};
  assign pc_inc = pc_q + 16'd1;
  // Only the low 8 address bits matter, so accesses wrap within dmem.
  assign ea    = vb[7:0] + imm6[7:0];
  assign ld    = dmem[ea];
  assign sum   = {1'b0, va} + {1'b0, vb};
  assign adi   = {1'b0, va} + {1'b0, imm6};
  assign nd    = ~(va & vb);
  assign pc    = pc_q;

  always_comb begin
    unique case (1'b1)
      cz == 2'b10: cond_ok = c_q;
      cz == 2'b01: cond_ok = z_q;
      cz == 2'b11: cond_ok = 1'b0;
      default:     cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    pc_d    = pc_inc;
    rf_d    = rf_q;
    c_d     = c_q;
    z_d     = z_q;
    dmem_we = 1'b0;
    case (op)
      OP_ADD: begin
        if (cond_ok) begin
          rf_d[rc] = sum[15:0];
          c_d      = sum[16];
          z_d      = (sum[15:0] == 16'h0000);
        end
      end
      OP_NDU: begin
        if (cond_ok) begin
          rf_d[rc] = nd;
          z_d      = (nd == 16'h0000);
        end
      end
      OP_ADI: begin
        rf_d[rb] = adi[15:0];
        c_d      = adi[16];
        z_d      = (adi[15:0] == 16'h0000);
      end
      OP_LHI: rf_d[ra] = {instr[8:0], 7'b0};
      OP_LW: begin
        rf_d[ra] = ld;
        z_d      = (ld == 16'h0000);
      end
      OP_SW:  dmem_we = 1'b1;
      OP_BEQ: begin
        if (va == vb) pc_d = pc_q + imm6;
      end
      OP_JAL: begin
        rf_d[ra] = pc_inc;
        pc_d     = pc_q + imm9;
      end
      // vb was sampled before the link write, so rA==rB still jumps to old rB.
      OP_JLR: begin
        rf_d[ra] = pc_inc;
        pc_d     = vb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 16'h0000;
      rf_q <= '{default: 16'h0000};
      c_q  <= 1'b0;
      z_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
      c_q  <= c_d;
      z_q  <= z_d;
    end
  end

  // imem has no write port; its preloaded contents are simply held.
  always_ff @(posedge clk) begin
    imem <= imem;
    if (dmem_we) dmem[ea] <= va;
  end

endmodule

// File: tb/tb_risc16_processor.sv
// tb_risc16_processor: directed programs with a queued scoreboard.
// Expectations are queued by stimulus and checked by a monitor.
module tb_risc16_processor;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;

  risc16_processor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_PC  = 0;
  localparam int K_REG = 1;
  localparam int K_MEM = 2;
  localparam int K_C   = 3;
  localparam int K_Z   = 4;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [15:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [15:0] actual(int kind, int idx);
    case (kind)
      K_PC:    return pc;
      K_REG:   return dut.rf_q[idx[2:0]];
      K_MEM:   return dut.dmem[idx[7:0]];
      K_C:     return {15'b0, dut.c_q};
      default: return {15'b0, dut.z_q};
    endcase
  endfunction

  // Monitor: samples on the falling edge, away from state updates.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        chk_t c;
        logic [15:0] a;
        c = q.pop_front();
        a = actual(c.kind, c.idx);
        n_tests++;
        if (a !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
        end
      end
    end
  end

  task automatic expect_v(string name, int kind, int idx, logic [15:0] exp);
    q.push_back('{name, kind, idx, exp});
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stops the core, loads a program and releases reset on a falling edge.
  task automatic load_and_start(input logic [15:0] prog [32],
                                input logic [15:0] fill);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = (i < 32) ? prog[i] : fill;
      dut.dmem[i] = 16'h0000;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] p [32];

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = 16'h0000;
      dut.dmem[i] = 16'h0000;
    end

    // Reset held, then an all-ADD R0 program.
    run(3);
    expect_v("rst_pc", K_PC, 0, 16'h0000);
    for (int r = 0; r < 8; r++) expect_v("rst_reg", K_REG, r, 16'h0000);
    expect_v("rst_c", K_C, 0, 16'h0000);
    expect_v("rst_z", K_Z, 0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    expect_v("nop_pc1", K_PC, 0, 16'h0001);
    run(4);
    expect_v("nop_pc5", K_PC, 0, 16'h0005);
    expect_v("nop_r0", K_REG, 0, 16'h0000);
    expect_v("nop_z", K_Z, 0, 16'h0001);
    expect_v("nop_c", K_C, 0, 16'h0000);

    // Arithmetic, flags and conditional R-type ops.
    p = '{default: 16'hF000};
    p[0] = {4'b0001, 3'd0, 3'd1, 6'd7};
    p[1] = {4'b0001, 3'd0, 3'd2, 6'h3F};
    p[2] = {4'b0000, 3'd1, 3'd2, 3'd3, 3'b000};
    p[3] = {4'b0001, 3'd0, 3'd7, 6'd0};
    p[4] = {4'b0000, 3'd1, 3'd1, 3'd4, 3'b010};
    p[5] = {4'b0000, 3'd1, 3'd1, 3'd5, 3'b001};
    p[6] = {4'b0010, 3'd1, 3'd2, 3'd6, 3'b000};
    p[7] = {4'b0010, 3'd1, 3'd1, 3'd4, 3'b010};
    p[8] = {4'b0000, 3'd1, 3'd1, 3'd4, 3'b011};
    load_and_start(p, 16'hF000);
    run(2);
    expect_v("adi_r1", K_REG, 1, 16'h0007);
    expect_v("adi_r2", K_REG, 2, 16'hFFFF);
    expect_v("adi_c", K_C, 0, 16'h0000);
    run(1);
    expect_v("add_r3", K_REG, 3, 16'h0006);
    expect_v("add_c", K_C, 0, 16'h0001);
    expect_v("add_z", K_Z, 0, 16'h0000);
    run(2);
    expect_v("adc_r4", K_REG, 4, 16'h0000);
    expect_v("adc_c", K_C, 0, 16'h0000);
    expect_v("adc_z", K_Z, 0, 16'h0001);
    run(1);
    expect_v("adz_r5", K_REG, 5, 16'h000E);
    expect_v("adz_z", K_Z, 0, 16'h0000);
    run(3);
    expect_v("ndu_r6", K_REG, 6, 16'hFFF8);
    expect_v("never_r4", K_REG, 4, 16'h0000);
    expect_v("ar_pc", K_PC, 0, 16'h0009);

    // Memory: LHI, SW, LW, zero load, wrapped address.
    p = '{default: 16'hF000};
    p[0] = {4'b0011, 3'd6, 9'h039};
    p[1] = {4'b0101, 3'd6, 3'd0, 6'd3};
    p[2] = {4'b0100, 3'd4, 3'd0, 6'd3};
    p[3] = {4'b0100, 3'd5, 3'd0, 6'd10};
    p[4] = {4'b0100, 3'd3, 3'd0, 6'h3F};
    load_and_start(p, 16'hF000);
    dut.dmem[255] = 16'hBEEF;
    run(2);
    expect_v("lhi_r6", K_REG, 6, 16'h1C80);
    expect_v("sw_mem3", K_MEM, 3, 16'h1C80);
    run(1);
    expect_v("lw_r4", K_REG, 4, 16'h1C80);
    expect_v("lw_z0", K_Z, 0, 16'h0000);
    run(1);
    expect_v("lw_z1", K_Z, 0, 16'h0001);
    run(1);
    expect_v("lw_wrap", K_REG, 3, 16'hBEEF);
    expect_v("lw_wrap_z", K_Z, 0, 16'h0000);

    // Control flow.
    p = '{default: {4'b0001, 3'd0, 3'd7, 6'd1}};
    p[0]  = {4'b0001, 3'd0, 3'd1, 6'd20};
    p[1]  = {4'b1100, 3'd0, 3'd0, 6'd6};
    p[7]  = {4'b1100, 3'd0, 3'd1, 6'd5};
    p[8]  = {4'b1000, 3'd2, 9'd3};
    p[11] = {4'b1001, 3'd5, 3'd1, 6'd0};
    p[20] = {4'b0001, 3'd0, 3'd3, 6'd25};
    p[21] = {4'b1001, 3'd3, 3'd3, 6'd0};
    p[25] = {4'b1000, 3'd4, 9'h1E7};
    load_and_start(p, 16'hF000);
    run(2);
    expect_v("beq_taken", K_PC, 0, 16'd7);
    run(1);
    expect_v("beq_not", K_PC, 0, 16'd8);
    run(1);
    expect_v("jal_pc", K_PC, 0, 16'd11);
    expect_v("jal_r2", K_REG, 2, 16'd9);
    run(1);
    expect_v("jlr_pc", K_PC, 0, 16'd20);
    expect_v("jlr_r5", K_REG, 5, 16'd12);
    run(2);
    expect_v("jlr_same_pc", K_PC, 0, 16'd25);
    expect_v("jlr_same_r3", K_REG, 3, 16'd22);
    run(1);
    expect_v("jal_neg_pc", K_PC, 0, 16'd0);
    expect_v("jal_neg_r4", K_REG, 4, 16'd26);
    expect_v("cf_r7", K_REG, 7, 16'd0);

    // Asynchronous reset mid-run.
    p = '{default: {4'b0001, 3'd1, 3'd1, 6'd1}};
    load_and_start(p, {4'b0001, 3'd1, 3'd1, 6'd1});
    run(6);
    expect_v("pre_rst_r1", K_REG, 1, 16'd6);
    expect_v("pre_rst_pc", K_PC, 0, 16'd6);
    run(1);
    rst_n = 1'b0;
    #1;
    expect_v("arst_pc", K_PC, 0, 16'd0);
    expect_v("arst_r1", K_REG, 1, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    expect_v("resume_pc", K_PC, 0, 16'd2);
    expect_v("resume_r1", K_REG, 1, 16'd2);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
